// File: rtl/spi_ram_pkg.sv
// Shared op encodings, FSM state type and header encoding for the SPI RAM master.
package spi_ram_pkg;

  typedef enum logic [1:0] {
    OP_WR_ADDR = 2'b00,
    OP_WR_DATA = 2'b01,
    OP_RD_ADDR = 2'b10,
    OP_RD_DATA = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEAD,
    ST_HEADER,
    ST_PAYLOAD,
    ST_TURN,
    ST_CAPTURE,
    ST_GAP
  } state_e;

  // Header is {sel, c1, c0} where sel is the read/write select bit of the op.
  function automatic logic [2:0] hdr_bits(input logic [1:0] op);
    return {op[1], op};
  endfunction

endpackage

// File: rtl/spi_sck_gen.sv
// SCK divider: toggles SCK every HALF_DIV clk cycles while run is high, and
// flags the clk edge that will drive each SCK transition.
module spi_sck_gen #(
  parameter int HALF_DIV = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  output logic SCK,
  output logic rise_tick,
  output logic fall_tick
);

  localparam int DW = $clog2(HALF_DIV) + 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(HALF_DIV - 1);

  logic [DW-1:0] div_cnt_q;
  logic          sck_q;
  logic          tick;

  assign tick      = run && (div_cnt_q == DIV_LAST);
  assign rise_tick = tick && !sck_q;
  assign fall_tick = tick && sck_q;
  assign SCK       = sck_q;

  always_ff @(posedge clk) begin
    if (rst || !run) begin
      div_cnt_q <= '0;
      sck_q     <= 1'b0;
    end else if (tick) begin
      div_cnt_q <= '0;
      sck_q     <= ~sck_q;
    end else begin
      div_cnt_q <= div_cnt_q + DW'(1);
    end
  end

endmodule

// File: rtl/spi_ram_master.sv
// SPI master turning one host command into one frame for the SPI-slave RAM
// wrapper; RD_DATA frames return the captured MISO byte as a one-cycle pulse.
module spi_ram_master
  import spi_ram_pkg::*;
#(
  parameter int HALF_DIV = 2,
  parameter int RD_TURN  = 1,
  parameter int GAP      = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_op,
  input  logic [7:0] cmd_data,
  output logic       rsp_valid,
  output logic [7:0] rsp_data,
  output logic       busy,
  output logic       SCK,
  output logic       SS_n,
  output logic       MOSI,
  input  logic       MISO
);

  localparam int GAP_CYC = GAP * 2 * HALF_DIV;
  localparam int GW      = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
  localparam logic [GW-1:0] GAP_LOAD  = GW'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);
  localparam logic [3:0]    TURN_LAST = 4'((RD_TURN > 0) ? RD_TURN - 1 : 0);

  state_e         state_q, state_d;
  logic [3:0]     bit_cnt_q, bit_cnt_d;
  logic [GW-1:0]  gap_cnt_q, gap_cnt_d;
  logic [1:0]     op_q, op_d;
  logic [10:0]    tx_q, tx_d;
  logic [7:0]     rx_q, rx_d;
  logic           mosi_q, mosi_d;
  logic           ss_n_q, ss_n_d;
  logic           rsp_valid_q, rsp_valid_d;
  logic [7:0]     rsp_data_q, rsp_data_d;

  logic run, rise_tick, fall_tick;

  assign run = state_q inside {ST_LEAD, ST_HEADER, ST_PAYLOAD, ST_TURN, ST_CAPTURE};

  spi_sck_gen #(.HALF_DIV(HALF_DIV)) u_sck_gen (
    .clk       (clk),
    .rst       (rst),
    .run       (run),
    .SCK       (SCK),
    .rise_tick (rise_tick),
    .fall_tick (fall_tick)
  );

  assign cmd_ready = (state_q == ST_IDLE) && !rst;
  assign busy      = (state_q != ST_IDLE);
  assign SS_n      = ss_n_q;
  assign MOSI      = mosi_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    gap_cnt_d   = gap_cnt_q;
    op_d        = op_q;
    tx_d        = tx_q;
    rx_d        = rx_q;
    mosi_d      = mosi_q;
    ss_n_d      = ss_n_q;
    rsp_valid_d = 1'b0;
    rsp_data_d  = rsp_data_q;

    unique case (state_q)
      ST_IDLE: begin
        if (cmd_valid && cmd_ready) begin
          state_d   = ST_LEAD;
          op_d      = cmd_op;
          tx_d      = {hdr_bits(cmd_op), (cmd_op == OP_RD_DATA) ? 8'h00 : cmd_data};
          bit_cnt_d = '0;
          mosi_d    = 1'b0;
          ss_n_d    = 1'b0;
        end
      end
      ST_LEAD: begin
        if (fall_tick) begin
          state_d   = ST_HEADER;
          bit_cnt_d = '0;
          mosi_d    = tx_q[10];
          tx_d      = {tx_q[9:0], 1'b0};
        end
      end
      // The third header fall already drives payload bit 7.
      ST_HEADER: begin
        if (fall_tick) begin
          mosi_d = tx_q[10];
          tx_d   = {tx_q[9:0], 1'b0};
          if (bit_cnt_q == 4'd2) begin
            state_d   = ST_PAYLOAD;
            bit_cnt_d = '0;
          end else begin
            bit_cnt_d = bit_cnt_q + 4'd1;
          end
        end
      end
      ST_PAYLOAD: begin
        if (fall_tick) begin
          if (bit_cnt_q == 4'd7) begin
            bit_cnt_d = '0;
            mosi_d    = 1'b0;
            if (op_q == OP_RD_DATA) begin
              state_d = (RD_TURN == 0) ? ST_CAPTURE : ST_TURN;
            end else begin
              state_d   = (GAP_CYC == 0) ? ST_IDLE : ST_GAP;
              ss_n_d    = 1'b1;
              gap_cnt_d = GAP_LOAD;
            end
          end else begin
            bit_cnt_d = bit_cnt_q + 4'd1;
            mosi_d    = tx_q[10];
            tx_d      = {tx_q[9:0], 1'b0};
          end
        end
      end
      ST_TURN: begin
        if (fall_tick) begin
          if (bit_cnt_q == TURN_LAST) begin
            state_d   = ST_CAPTURE;
            bit_cnt_d = '0;
          end else begin
            bit_cnt_d = bit_cnt_q + 4'd1;
          end
        end
      end
      ST_CAPTURE: begin
        if (rise_tick) begin
          rx_d = {rx_q[6:0], MISO};
        end
        if (fall_tick) begin
          if (bit_cnt_q == 4'd7) begin
            bit_cnt_d   = '0;
            rsp_data_d  = rx_q;
            rsp_valid_d = 1'b1;
            state_d     = (GAP_CYC == 0) ? ST_IDLE : ST_GAP;
            ss_n_d      = 1'b1;
            gap_cnt_d   = GAP_LOAD;
          end else begin
            bit_cnt_d = bit_cnt_q + 4'd1;
          end
        end
      end
      ST_GAP: begin
        if (gap_cnt_q == '0) begin
          state_d = ST_IDLE;
        end else begin
          gap_cnt_d = gap_cnt_q - GW'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        ss_n_d  = 1'b1;
        mosi_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      bit_cnt_q   <= '0;
      gap_cnt_q   <= '0;
      op_q        <= '0;
      tx_q        <= '0;
      rx_q        <= '0;
      mosi_q      <= 1'b0;
      ss_n_q      <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      gap_cnt_q   <= gap_cnt_d;
      op_q        <= op_d;
      tx_q        <= tx_d;
      rx_q        <= rx_d;
      mosi_q      <= mosi_d;
      ss_n_q      <= ss_n_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

endmodule

// File: tb/tb_spi_ram_master.sv
// Bench for spi_ram_master: behavioural SPI-slave RAM wrapper, queued host
// commands, and a scoreboard monitor checking frames and responses.
module tb_spi_ram_master;
  import spi_ram_pkg::*;

  localparam int HALF_DIV = 1;
  localparam int RD_TURN  = 1;
  localparam int GAP      = 2;
  localparam int GAP_CYC  = GAP * 2 * HALF_DIV;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cmd_valid = 1'b0;
  logic [1:0] cmd_op = 2'b00;
  logic [7:0] cmd_data = 8'h00;
  logic       MISO = 1'b0;
  logic       cmd_ready, rsp_valid, busy, SCK, SS_n, MOSI;
  logic [7:0] rsp_data;

  always #5 clk = ~clk;

  spi_ram_master #(.HALF_DIV(HALF_DIV), .RD_TURN(RD_TURN), .GAP(GAP)) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_data  (cmd_data),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .busy      (busy),
    .SCK       (SCK),
    .SS_n      (SS_n),
    .MOSI      (MOSI),
    .MISO      (MISO)
  );

  typedef struct {
    logic [20:0] bits;
    int          nbits;
    int          cycles;
  } frame_t;

  frame_t     exp_frames[$];
  logic [7:0] exp_rsp[$];
  logic [9:0] cmd_q[$];
  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic send(input logic [1:0] op, input logic [7:0] data,
                      input logic [20:0] bits, input int nbits, input logic [7:0] rsp);
    frame_t f;
    f.bits   = bits;
    f.nbits  = nbits;
    f.cycles = nbits * 2 * HALF_DIV;
    exp_frames.push_back(f);
    if (op == OP_RD_DATA) exp_rsp.push_back(rsp);
    cmd_q.push_back({op, data});
  endtask

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while ((cmd_q.size() != 0 || busy !== 1'b0) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 2000) begin
      vectors++;
      miscompares++;
      $display("FAIL idle_timeout: got busy=%0b, expected 0 within 2000 cycles", busy);
    end
  endtask

  // Host driver: holds cmd_valid while commands are queued.
  initial begin
    bit acc;
    forever begin
      @(negedge clk);
      acc = (cmd_valid && cmd_ready === 1'b1);
      if (acc) check("accept_in_idle_busy", {31'd0, busy}, 32'd0);
      @(posedge clk);
      if (acc) void'(cmd_q.pop_front());
      #1;
      if (cmd_q.size() > 0) begin
        cmd_valid = 1'b1;
        {cmd_op, cmd_data} = cmd_q[0];
      end else begin
        cmd_valid = 1'b0;
      end
    end
  end

  // Slave RAM wrapper model: samples MOSI on SCK rise, drives MISO after SCK fall.
  int         s_cnt = 0;
  logic [11:0] s_sh = '0;
  logic       s_prev_sck = 1'b0;
  logic [7:0] s_wa = 8'h00, s_ra = 8'h00, s_rd_byte = 8'h00;
  logic [7:0] ram [256];

  initial begin
    int j;
    for (int i = 0; i < 256; i++) ram[i] = 8'h00;
    forever begin
      @(negedge clk);
      if (SS_n !== 1'b0) begin
        s_cnt = 0;
        s_sh  = '0;
        MISO  = 1'b0;
      end else begin
        if (SCK === 1'b1 && s_prev_sck === 1'b0) begin
          s_sh = {s_sh[10:0], MOSI};
          s_cnt++;
          if (s_cnt == 12) begin
            case (s_sh[10:8])
              3'b000:  s_wa = s_sh[7:0];
              3'b001:  ram[s_wa] = s_sh[7:0];
              3'b110:  s_ra = s_sh[7:0];
              3'b111:  s_rd_byte = ram[s_ra];
              default: ;
            endcase
          end
        end
        if (SCK === 1'b0 && s_prev_sck === 1'b1) begin
          j = s_cnt - 12 - RD_TURN;
          if (j >= 0 && j < 8) MISO = s_rd_byte[7-j];
          else MISO = 1'b0;
        end
      end
      s_prev_sck = SCK;
    end
  end

  // Scoreboard monitor: compares each completed frame and each response pulse.
  initial begin
    logic [20:0] m_bits = '0;
    int   m_nbits = 0, ss_low = 0, ss_high = 0;
    bit   busy_ok = 1'b1, seen_frame = 1'b0;
    logic prev_ss = 1'b1, prev_sck = 1'b0;
    frame_t f;
    logic [7:0] r;
    forever begin
      @(negedge clk);
      if (SS_n === 1'b0) begin
        if (prev_ss === 1'b1) begin
          if (seen_frame) check("ss_n_high_gap_ok", {31'd0, ss_high >= GAP_CYC}, 32'd1);
          m_bits  = '0;
          m_nbits = 0;
          ss_low  = 0;
          busy_ok = 1'b1;
        end
        ss_low++;
        if (busy !== 1'b1) busy_ok = 1'b0;
        if (SCK === 1'b1 && prev_sck === 1'b0) begin
          m_bits = {m_bits[19:0], MOSI};
          m_nbits++;
        end
      end else begin
        if (prev_ss === 1'b0) begin
          if (rst !== 1'b1) begin
            if (exp_frames.size() == 0) begin
              vectors++;
              miscompares++;
              $display("FAIL spurious_frame: got frame bits 0x%0h, expected no frame", m_bits);
            end else begin
              f = exp_frames.pop_front();
              check("frame_mosi_bits", {11'd0, m_bits}, {11'd0, f.bits});
              check("frame_sck_periods", m_nbits, f.nbits);
              check("frame_ss_low_cycles", ss_low, f.cycles);
              check("frame_busy_high", {31'd0, busy_ok}, 32'd1);
            end
          end
          seen_frame = 1'b1;
          ss_high = 0;
        end
        ss_high++;
      end
      if (rsp_valid === 1'b1) begin
        if (exp_rsp.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL spurious_rsp: got rsp_data 0x%0h, expected no response", rsp_data);
        end else begin
          r = exp_rsp.pop_front();
          check("rsp_data", {24'd0, rsp_data}, {24'd0, r});
        end
      end
      prev_ss  = SS_n;
      prev_sck = SCK;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no completion, expected finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_ss_n", {31'd0, SS_n}, 32'd1);
    check("rst_sck", {31'd0, SCK}, 32'd0);
    check("rst_mosi", {31'd0, MOSI}, 32'd0);
    check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("rst_rsp_data", {24'd0, rsp_data}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_cmd_ready", {31'd0, cmd_ready}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("cmd_ready_after_rst", {31'd0, cmd_ready}, 32'd1);

    // WR_ADDR 0xA5: lead 0, header 000, payload 10100101
    send(OP_WR_ADDR, 8'hA5, 21'h0A5, 12, 8'h00);
    wait_idle();
    check("slave_wr_addr", {24'd0, s_wa}, 32'h0A5);

    send(OP_WR_ADDR, 8'h10, 21'h010, 12, 8'h00);
    send(OP_WR_DATA, 8'h3C, 21'h13C, 12, 8'h00);
    wait_idle();
    check("ram_0x10", {24'd0, ram[8'h10]}, 32'h03C);
    check("rsp_data_idle_after_writes", {24'd0, rsp_data}, 32'h000);

    // RD_DATA payload byte is ignored; stream is 0,111,0x00,turn 0,8 zeros
    send(OP_RD_ADDR, 8'h10, 21'h610, 12, 8'h00);
    send(OP_RD_DATA, 8'hFF, 21'hE0000, 21, 8'h3C);
    wait_idle();
    check("rsp_data_hold", {24'd0, rsp_data}, 32'h03C);

    send(OP_WR_ADDR, 8'h20, 21'h020, 12, 8'h00);
    send(OP_WR_DATA, 8'h5A, 21'h15A, 12, 8'h00);
    send(OP_RD_ADDR, 8'h20, 21'h620, 12, 8'h00);
    send(OP_RD_DATA, 8'h00, 21'hE0000, 21, 8'h5A);
    wait_idle();
    check("ram_0x20", {24'd0, ram[8'h20]}, 32'h05A);

    // RD_DATA aborted by reset during its capture phase
    cmd_q.push_back({OP_RD_DATA, 8'h00});
    n = 0;
    while (s_cnt < 16 && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (n >= 500) begin
      vectors++;
      miscompares++;
      $display("FAIL capture_reach_timeout: got %0d SCK rises, expected 16", s_cnt);
    end
    rst = 1'b1;
    repeat (5) begin
      @(negedge clk);
      check("abort_ss_n", {31'd0, SS_n}, 32'd1);
      check("abort_sck", {31'd0, SCK}, 32'd0);
      check("abort_mosi", {31'd0, MOSI}, 32'd0);
      check("abort_rsp_valid", {31'd0, rsp_valid}, 32'd0);
      check("abort_cmd_ready", {31'd0, cmd_ready}, 32'd0);
      check("abort_busy", {31'd0, busy}, 32'd0);
    end
    check("abort_rsp_data_reset", {24'd0, rsp_data}, 32'h000);
    rst = 1'b0;
    @(negedge clk);
    check("cmd_ready_after_abort", {31'd0, cmd_ready}, 32'd1);

    send(OP_RD_DATA, 8'h00, 21'hE0000, 21, 8'h5A);
    wait_idle();
    repeat (5) @(negedge clk);
    check("frames_outstanding", exp_frames.size(), 32'd0);
    check("rsp_outstanding", exp_rsp.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
